// File: rtl/branch_resolution_unit_pkg.sv
// Shared constants and types for the branch resolution unit.
// - WORD_SIZE      : PC/data width used by every stage of the unit.
// - ctrl_class_e   : control-transfer class of the instruction in ID.
// - bht_req_t      : one BHT update request {valid, correct, pc}.
package branch_resolution_unit_pkg;

  localparam int unsigned WORD_SIZE = 16;

  typedef enum logic [1:0] {
    CtrlNone,
    CtrlJump,
    CtrlBranch
  } ctrl_class_e;

  typedef struct packed {
    logic                 valid;
    logic                 correct;
    logic [WORD_SIZE-1:0] pc;
  } bht_req_t;

  // A conditional branch wins over the jump flag so one instruction never earns two BHT updates.
  function automatic ctrl_class_e classify(input logic is_jump, input logic is_branch);
    ctrl_class_e cls;
    cls = CtrlNone;
    if (is_branch) begin
      cls = CtrlBranch;
    end else if (is_jump) begin
      cls = CtrlJump;
    end
    return cls;
  endfunction

endpackage

// File: rtl/branch_resolution_unit_sat_counter.sv
// Saturating up-counter used for the performance counters.
// Ports:
// - clk     : clock, state on posedge
// - reset_n : asynchronous active-low reset, clears the count
// - inc     : add one this cycle (ignored once the count is all-ones)
// - count   : current count
module branch_resolution_unit_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: tracks fetched PCs and predicted next PCs through ID and EX, resolves
// direct jumps in ID and conditional branches in EX, updates the BTB/BHT, redirects and flushes
// the pipeline, and counts resolved and mispredicted control transfers.
// Ports:
// - clk, reset_n                        : clock and asynchronous active-low reset
// - stall                               : hazard stall (hold IF/ID, bubble into ID/EX)
// - inst_valid_if, pc_if, predicted_pc_if: fetched instruction and its predicted next PC
// - is_jump_id, is_branch_id, target_id : decode info of the instruction in ID
// - branch_taken_ex                     : branch condition for the instruction in EX
// - update_tag, pc_for_btb_update, branch_target_for_btb_update : BTB write port
// - update_bht, pc_for_bht_update, branch_correct_or_notCorrect  : BHT update port
// - redirect_valid, redirect_pc         : corrected next PC for the PC register
// - flush_if, flush_id                  : squash IF / ID instructions
// - num_branch, num_mispredict          : saturating performance counters
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int unsigned PERF_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      inst_valid_if,
  input  logic [WORD_SIZE-1:0]      pc_if,
  input  logic [WORD_SIZE-1:0]      predicted_pc_if,
  input  logic                      is_jump_id,
  input  logic                      is_branch_id,
  input  logic [WORD_SIZE-1:0]      target_id,
  input  logic                      branch_taken_ex,
  output logic                      update_tag,
  output logic [WORD_SIZE-1:0]      pc_for_btb_update,
  output logic [WORD_SIZE-1:0]      branch_target_for_btb_update,
  output logic                      update_bht,
  output logic [WORD_SIZE-1:0]      pc_for_bht_update,
  output logic                      branch_correct_or_notCorrect,
  output logic                      redirect_valid,
  output logic [WORD_SIZE-1:0]      redirect_pc,
  output logic                      flush_if,
  output logic                      flush_id,
  output logic [PERF_CNT_WIDTH-1:0] num_branch,
  output logic [PERF_CNT_WIDTH-1:0] num_mispredict
);

  // IF/ID register
  logic [WORD_SIZE-1:0] pc_id_q, pred_id_q;
  logic                 valid_id_q;
  logic                 id_done_q, id_done_d;

  // ID/EX register
  logic [WORD_SIZE-1:0] pc_ex_q, pred_ex_q, target_ex_q;
  logic                 is_branch_ex_q, valid_ex_q;

  // Deferred ID jump update that lost the BHT port
  bht_req_t pend_q, pend_d;

  ctrl_class_e          id_class;
  logic                 ex_resolve, ex_correct, ex_mispredict;
  logic [WORD_SIZE-1:0] ex_actual;
  logic                 id_fire, id_jump_upd, id_jump_correct, id_jump_mispredict;
  logic                 pend_load;

  // ---------------------------------------------------------------------------
  // EX resolution
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_resolve    = valid_ex_q & is_branch_ex_q;
    ex_actual     = branch_taken_ex ? target_ex_q
                                    : pc_ex_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
    ex_correct    = (ex_actual == pred_ex_q);
    ex_mispredict = ex_resolve & ~ex_correct;
  end

  // ---------------------------------------------------------------------------
  // ID resolution; a mispredicting branch in EX means ID holds a wrong-path instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    id_class           = classify(is_jump_id, is_branch_id);
    id_fire            = valid_id_q & ~id_done_q & (id_class != CtrlNone) & ~ex_mispredict;
    id_jump_upd        = id_fire & (id_class == CtrlJump);
    id_jump_correct    = (target_id == pred_id_q);
    id_jump_mispredict = id_jump_upd & ~id_jump_correct;
  end

  // ---------------------------------------------------------------------------
  // BHT port arbitration (EX > pending > ID jump) and pending-entry next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // The ID jump must wait whenever EX or the pending entry already owns the port.
    pend_load = id_jump_upd & (ex_resolve | pend_q.valid);
    pend_d    = pend_q;
    if (pend_load) begin
      pend_d.valid   = 1'b1;
      pend_d.correct = id_jump_correct;
      pend_d.pc      = pc_id_q;
    end else if (!ex_resolve) begin
      // Port was free of EX, so any pending entry drained this cycle.
      pend_d.valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (combinational, zero-latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    update_tag                   = 1'b0;
    pc_for_btb_update            = '0;
    branch_target_for_btb_update = '0;
    update_bht                   = 1'b0;
    pc_for_bht_update            = '0;
    branch_correct_or_notCorrect = 1'b0;
    redirect_valid               = 1'b0;
    redirect_pc                  = '0;
    flush_if                     = 1'b0;
    flush_id                     = 1'b0;

    if (id_fire) begin
      update_tag                   = 1'b1;
      pc_for_btb_update            = pc_id_q;
      branch_target_for_btb_update = target_id;
    end

    if (ex_resolve) begin
      update_bht                   = 1'b1;
      pc_for_bht_update            = pc_ex_q;
      branch_correct_or_notCorrect = ex_correct;
    end else if (pend_q.valid) begin
      update_bht                   = 1'b1;
      pc_for_bht_update            = pend_q.pc;
      branch_correct_or_notCorrect = pend_q.correct;
    end else if (id_jump_upd) begin
      update_bht                   = 1'b1;
      pc_for_bht_update            = pc_id_q;
      branch_correct_or_notCorrect = id_jump_correct;
    end

    if (ex_mispredict) begin
      redirect_valid = 1'b1;
      redirect_pc    = ex_actual;
      flush_if       = 1'b1;
      flush_id       = 1'b1;
    end else if (id_jump_mispredict) begin
      redirect_valid = 1'b1;
      redirect_pc    = target_id;
      flush_if       = 1'b1;
    end
  end

  // id_done blocks a stalled instruction from firing twice; it clears once ID moves on.
  always_comb begin
    id_done_d = id_done_q | id_fire;
    if (flush_if || !stall) begin
      id_done_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_id_q    <= '0;
      pred_id_q  <= '0;
      valid_id_q <= 1'b0;
      id_done_q  <= 1'b0;
    end else begin
      id_done_q <= id_done_d;
      if (flush_if) begin
        valid_id_q <= 1'b0;
      end else if (!stall) begin
        pc_id_q    <= pc_if;
        pred_id_q  <= predicted_pc_if;
        valid_id_q <= inst_valid_if;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_ex_q        <= '0;
      pred_ex_q      <= '0;
      target_ex_q    <= '0;
      is_branch_ex_q <= 1'b0;
      valid_ex_q     <= 1'b0;
    end else if (flush_id || stall) begin
      valid_ex_q <= 1'b0;
    end else begin
      pc_ex_q        <= pc_id_q;
      pred_ex_q      <= pred_id_q;
      target_ex_q    <= target_id;
      is_branch_ex_q <= is_branch_id;
      valid_ex_q     <= valid_id_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  branch_resolution_unit_sat_counter #(
    .WIDTH(PERF_CNT_WIDTH)
  ) u_cnt_branch (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (update_bht),
    .count  (num_branch)
  );

  branch_resolution_unit_sat_counter #(
    .WIDTH(PERF_CNT_WIDTH)
  ) u_cnt_mispredict (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (update_bht & ~branch_correct_or_notCorrect),
    .count  (num_mispredict)
  );

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: per-cycle directed vectors plus hand sequences
// for mid-run reset and counter saturation (a narrow-counter second instance).
module tb_branch_resolution_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         stall, inst_valid_if, is_jump_id, is_branch_id, branch_taken_ex;
  logic [W-1:0] pc_if, predicted_pc_if, target_id;

  logic         update_tag, update_bht, branch_correct, redirect_valid, flush_if, flush_id;
  logic [W-1:0] pc_btb, tgt_btb, pc_bht, redirect_pc, num_branch, num_mispredict;

  logic          s_update_tag, s_update_bht, s_correct, s_redirect_valid, s_flush_if, s_flush_id;
  logic [W-1:0]  s_pc_btb, s_tgt_btb, s_pc_bht, s_redirect_pc;
  logic [SW-1:0] s_num_branch, s_num_mispredict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(.PERF_CNT_WIDTH(W)) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .stall                       (stall),
    .inst_valid_if               (inst_valid_if),
    .pc_if                       (pc_if),
    .predicted_pc_if             (predicted_pc_if),
    .is_jump_id                  (is_jump_id),
    .is_branch_id                (is_branch_id),
    .target_id                   (target_id),
    .branch_taken_ex             (branch_taken_ex),
    .update_tag                  (update_tag),
    .pc_for_btb_update           (pc_btb),
    .branch_target_for_btb_update(tgt_btb),
    .update_bht                  (update_bht),
    .pc_for_bht_update           (pc_bht),
    .branch_correct_or_notCorrect(branch_correct),
    .redirect_valid              (redirect_valid),
    .redirect_pc                 (redirect_pc),
    .flush_if                    (flush_if),
    .flush_id                    (flush_id),
    .num_branch                  (num_branch),
    .num_mispredict              (num_mispredict)
  );

  branch_resolution_unit #(.PERF_CNT_WIDTH(SW)) dut_small (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .stall                       (stall),
    .inst_valid_if               (inst_valid_if),
    .pc_if                       (pc_if),
    .predicted_pc_if             (predicted_pc_if),
    .is_jump_id                  (is_jump_id),
    .is_branch_id                (is_branch_id),
    .target_id                   (target_id),
    .branch_taken_ex             (branch_taken_ex),
    .update_tag                  (s_update_tag),
    .pc_for_btb_update           (s_pc_btb),
    .branch_target_for_btb_update(s_tgt_btb),
    .update_bht                  (s_update_bht),
    .pc_for_bht_update           (s_pc_bht),
    .branch_correct_or_notCorrect(s_correct),
    .redirect_valid              (s_redirect_valid),
    .redirect_pc                 (s_redirect_pc),
    .flush_if                    (s_flush_if),
    .flush_id                    (s_flush_id),
    .num_branch                  (s_num_branch),
    .num_mispredict              (s_num_mispredict)
  );

  // strb = {update_tag, update_bht, correct, redirect_valid, flush_if, flush_id}
  typedef struct packed {
    logic         stall;
    logic         iv;
    logic [W-1:0] pc;
    logic [W-1:0] pred;
    logic         jmp;
    logic         br;
    logic [W-1:0] tgt;
    logic         tk;
    logic [5:0]   strb;
    logic [W-1:0] btb_pc;
    logic [W-1:0] btb_tgt;
    logic [W-1:0] bht_pc;
    logic [W-1:0] rpc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic iv, input logic [W-1:0] pc,
                              input logic [W-1:0] pred, input logic jmp, input logic br,
                              input logic [W-1:0] tgt, input logic tk, input logic [5:0] strb,
                              input logic [W-1:0] btb_pc, input logic [W-1:0] btb_tgt,
                              input logic [W-1:0] bht_pc, input logic [W-1:0] rpc);
    vec_t v;
    v.stall = st; v.iv = iv; v.pc = pc; v.pred = pred; v.jmp = jmp; v.br = br;
    v.tgt = tgt; v.tk = tk; v.strb = strb; v.btb_pc = btb_pc; v.btb_tgt = btb_tgt;
    v.bht_pc = bht_pc; v.rpc = rpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic iv, input logic [W-1:0] pc,
                        input logic [W-1:0] pred, input logic jmp, input logic br,
                        input logic [W-1:0] tgt, input logic tk);
    stall = st; inst_valid_if = iv; pc_if = pc; predicted_pc_if = pred;
    is_jump_id = jmp; is_branch_id = br; target_id = tgt; branch_taken_ex = tk;
  endtask

  function automatic logic [5:0] strobes();
    return {update_tag, update_bht, branch_correct, redirect_valid, flush_if, flush_id};
  endfunction

  function automatic logic [63:0] buses();
    return {pc_btb, tgt_btb, pc_bht, redirect_pc};
  endfunction

  // Pending overflow must never happen: a held jump update plus a new EX and ID update.
  always @(negedge clk) begin
    if (reset_n && dut.pend_q.valid && dut.ex_resolve && dut.id_jump_upd) begin
      errors++;
      $display("FAIL pend_overflow at %0t", $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    //                 st iv pc        pred     j  b  tgt      tk strb       btbpc    btbtgt   bhtpc    rpc
    vecs[0]  = mk(0, 1, 16'h0010, 16'h0011, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[1]  = mk(0, 1, 16'h0011, 16'h0012, 1, 0, 16'h0040, 0, 6'b110110,
                  16'h0010, 16'h0040, 16'h0010, 16'h0040);
    vecs[2]  = mk(0, 1, 16'h0040, 16'h0041, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[3]  = mk(0, 1, 16'h0041, 16'h0042, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[4]  = mk(0, 1, 16'h0020, 16'h0030, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[5]  = mk(0, 1, 16'h0030, 16'h0031, 0, 1, 16'h0030, 0, 6'b100000,
                  16'h0020, 16'h0030, 16'h0, 16'h0);
    vecs[6]  = mk(0, 1, 16'h0031, 16'h0032, 0, 0, 16'h0000, 1, 6'b011000,
                  16'h0, 16'h0, 16'h0020, 16'h0);
    vecs[7]  = mk(0, 1, 16'h0032, 16'h0033, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[8]  = mk(0, 1, 16'h0020, 16'h0030, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[9]  = mk(0, 1, 16'h0030, 16'h0050, 0, 1, 16'h0030, 0, 6'b100000,
                  16'h0020, 16'h0030, 16'h0, 16'h0);
    vecs[10] = mk(0, 1, 16'h0050, 16'h0051, 1, 0, 16'h0060, 0, 6'b010111,
                  16'h0, 16'h0, 16'h0020, 16'h0021);
    vecs[11] = mk(0, 1, 16'h0021, 16'h0022, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[12] = mk(0, 1, 16'h0022, 16'h0023, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[13] = mk(0, 1, 16'h0020, 16'h0031, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[14] = mk(0, 1, 16'h0031, 16'h0070, 0, 1, 16'h0031, 0, 6'b100000,
                  16'h0020, 16'h0031, 16'h0, 16'h0);
    vecs[15] = mk(0, 1, 16'h0070, 16'h0071, 1, 0, 16'h0070, 1, 6'b111000,
                  16'h0031, 16'h0070, 16'h0020, 16'h0);
    vecs[16] = mk(0, 1, 16'h0071, 16'h0072, 0, 0, 16'h0000, 0, 6'b011000,
                  16'h0, 16'h0, 16'h0031, 16'h0);
    vecs[17] = mk(0, 1, 16'h0072, 16'h0073, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[18] = mk(0, 1, 16'h0080, 16'h0090, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[19] = mk(1, 1, 16'h0090, 16'h0091, 1, 0, 16'h0090, 0, 6'b111000,
                  16'h0080, 16'h0090, 16'h0080, 16'h0);
    vecs[20] = mk(1, 1, 16'h0090, 16'h0091, 1, 0, 16'h0090, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[21] = mk(1, 1, 16'h0090, 16'h0091, 1, 0, 16'h0090, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[22] = mk(0, 1, 16'h0090, 16'h0091, 1, 0, 16'h0090, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[23] = mk(0, 1, 16'h0091, 16'h0092, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[24] = mk(0, 1, 16'h0020, 16'h0031, 0, 0, 16'h0000, 0, 6'b000000, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[25] = mk(0, 1, 16'h0031, 16'h0070, 0, 1, 16'h0031, 0, 6'b100000,
                  16'h0020, 16'h0031, 16'h0, 16'h0);
    vecs[26] = mk(0, 1, 16'h0070, 16'h0071, 1, 0, 16'h0070, 1, 6'b111000,
                  16'h0031, 16'h0070, 16'h0020, 16'h0);

    reset_n = 1'b0;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_strobes", 64'(strobes()), 64'h0);
    chk("reset_buses", buses(), 64'h0);
    chk("reset_counters", {num_branch, num_mispredict}, 64'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      set_in(vecs[i].stall, vecs[i].iv, vecs[i].pc, vecs[i].pred, vecs[i].jmp, vecs[i].br,
             vecs[i].tgt, vecs[i].tk);
      #1;
      chk($sformatf("row%0d_strobes", i), 64'(strobes()), 64'(vecs[i].strb));
      chk($sformatf("row%0d_buses", i), buses(),
          {vecs[i].btb_pc, vecs[i].btb_tgt, vecs[i].bht_pc, vecs[i].rpc});
      if (i == 2) begin
        chk("cnt_after_jump", {num_branch, num_mispredict}, {16'd1, 16'd1});
      end
      if (i == 23) begin
        chk("cnt_after_table", {num_branch, num_mispredict}, {16'd6, 16'd2});
      end
    end

    // Pending drain cycle, then reset asserted inside it.
    @(posedge clk);
    #1;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    #1;
    chk("pend_drain_strobes", 64'(strobes()), 64'(6'b011000));
    chk("pend_drain_pc", 64'(pc_bht), 64'h0031);
    chk("cnt_before_reset", {num_branch, num_mispredict}, {16'd7, 16'd2});
    reset_n = 1'b0;
    #1;
    chk("midreset_strobes", 64'(strobes()), 64'h0);
    chk("midreset_buses", buses(), 64'h0);
    chk("midreset_counters", {num_branch, num_mispredict}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk($sformatf("post_reset%0d_strobes", i), 64'(strobes()), 64'h0);
    end

    // Back-to-back jump mispredicts; the narrow instance must stick at all-ones.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      set_in(0, 1, 16'h0100 + 16'(2 * i), 16'h0101 + 16'(2 * i), 0, 0, 16'h0, 0);
      #1;
      if (i == 5) chk("small_mis_5", 64'(s_num_mispredict), 64'd5);
      if (i == 7) chk("small_mis_7", 64'(s_num_mispredict), 64'd7);
      if (i == 9) chk("small_mis_hold", 64'(s_num_mispredict), 64'd7);
      @(posedge clk);
      #1;
      set_in(0, 1, 16'h0300, 16'h0301, 1, 0, 16'h0200, 0);
      #1;
      chk($sformatf("sat%0d_strobes", i), 64'(strobes()), 64'(6'b110110));
      chk($sformatf("sat%0d_redirect", i), 64'(redirect_pc), 64'h0200);
    end
    @(posedge clk);
    #1;
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
    #1;
    chk("small_sat_final", {61'(0), s_num_branch}, 64'd7);
    chk("small_sat_mis_final", 64'(s_num_mispredict), 64'd7);
    chk("main_cnt_final", {num_branch, num_mispredict}, {16'd10, 16'd10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
